// File: rtl/proc_pkg.sv
// rtl/proc_pkg.sv - shared opcodes, instruction layout and sequencer states
// Instruction word is {F[5:4], Rx[3:2], Ry[1:0]}.
package proc_pkg;

  localparam logic [1:0] F_LOAD = 2'b00;
  localparam logic [1:0] F_MOVE = 2'b01;
  localparam logic [1:0] F_SUB  = 2'b10;
  localparam logic [1:0] F_ADD  = 2'b11;

  localparam int FIELD_W = 2;
  localparam int INSTR_W = 3 * FIELD_W;

  typedef struct packed {
    logic [FIELD_W-1:0] f;
    logic [FIELD_W-1:0] rx;
    logic [FIELD_W-1:0] ry;
  } instr_t;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_ERR   = 2'd3
  } seq_state_e;

  function automatic logic [INSTR_W-1:0] make_instr(input logic [FIELD_W-1:0] f,
                                                    input logic [FIELD_W-1:0] rx,
                                                    input logic [FIELD_W-1:0] ry);
    return {f, rx, ry};
  endfunction

endpackage

// File: rtl/seq_fifo.sv
// rtl/seq_fifo.sv - instruction FIFO with push, pop, flush and occupancy
// Head entry is read combinationally; flush wins over a same-cycle push.
module seq_fifo
  import proc_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int WIDTH = INSTR_W
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push_i,
  input  logic                       pop_i,
  input  logic                       flush_i,
  input  logic [WIDTH-1:0]           wdata_i,
  output logic [WIDTH-1:0]           rdata_o,
  output logic                       full_o,
  output logic                       empty_o,
  output logic [$clog2(DEPTH):0]     level_o
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [AW:0]      level_q, level_d;
  logic             do_push, do_pop;

  assign full_o  = (level_q == (AW+1)'(DEPTH));
  assign empty_o = (level_q == '0);
  assign level_o = level_q;
  assign rdata_o = mem_q[rd_ptr_q];

  assign do_push = push_i && !full_o && !flush_i;
  assign do_pop  = pop_i && !empty_o && !flush_i;

  always_comb begin
    level_d = level_q;
    if (do_push && !do_pop) level_d = level_q + 1'b1;
    else if (do_pop && !do_push) level_d = level_q - 1'b1;
  end

  // Pointers are AW bits wide, so they wrap modulo DEPTH for free.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else if (flush_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      level_q <= level_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata_i;
  end

endmodule

// File: rtl/proc_seq.sv
// rtl/proc_seq.sv - issues queued instructions to proc_fsm one at a time
// Waits for Done per instruction; a watchdog parks the sequencer in S_ERR.
module proc_seq
  import proc_pkg::*;
#(
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [5:0]             in_instr,
  input  logic                   flush,
  input  logic                   clr_err,
  output logic                   w,
  output logic [1:0]             F,
  output logic [1:0]             Rx,
  output logic [1:0]             Ry,
  input  logic                   Done,
  output logic                   busy,
  output logic                   err,
  output logic [7:0]             done_cnt,
  output logic [$clog2(DEPTH):0] level
);

  localparam int TW = $clog2(TIMEOUT) + 1;

  seq_state_e         state_q;
  instr_t             cur_q;
  logic [TW-1:0]      timer_q, timer_d;
  logic [7:0]         cnt_q, cnt_d;
  logic               w_q, busy_q, err_q;
  logic               fifo_full, fifo_empty, push, pop;
  logic [INSTR_W-1:0] head;

  assign in_ready = !fifo_full;
  assign push     = in_valid && !fifo_full && !flush;
  // A flush empties the queue, so nothing may be popped in that cycle.
  assign pop      = !flush && !fifo_empty &&
                    ((state_q == S_IDLE) || (state_q == S_WAIT && Done));
  assign timer_d  = timer_q + TW'(1);
  assign cnt_d    = cnt_q + 8'd1;

  seq_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (INSTR_W)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (push),
    .pop_i   (pop),
    .flush_i (flush),
    .wdata_i (in_instr),
    .rdata_o (head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .level_o (level)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      cur_q   <= '0;
      timer_q <= '0;
      cnt_q   <= '0;
      w_q     <= 1'b0;
      busy_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      w_q <= 1'b0;
      if (pop) cur_q <= head;
      case (state_q)
        S_IDLE: begin
          if (pop) begin
            state_q <= S_ISSUE;
            w_q     <= 1'b1;
            busy_q  <= 1'b1;
          end
        end
        S_ISSUE: begin
          timer_q <= '0;
          state_q <= S_WAIT;
        end
        S_WAIT: begin
          if (Done) begin
            cnt_q <= cnt_d;
            if (pop) begin
              state_q <= S_ISSUE;
              w_q     <= 1'b1;
            end else begin
              state_q <= S_IDLE;
              busy_q  <= 1'b0;
            end
          end else if (timer_q == TW'(TIMEOUT - 1)) begin
            state_q <= S_ERR;
            err_q   <= 1'b1;
            busy_q  <= 1'b0;
          end else begin
            timer_q <= timer_d;
          end
        end
        S_ERR: begin
          if (clr_err) begin
            err_q   <= 1'b0;
            state_q <= S_IDLE;
          end
        end
        default: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign w        = w_q;
  assign F        = cur_q.f;
  assign Rx       = cur_q.rx;
  assign Ry       = cur_q.ry;
  assign busy     = busy_q;
  assign err      = err_q;
  assign done_cnt = cnt_q;

endmodule

// File: tb/tb_proc_seq.sv
// tb/tb_proc_seq.sv - directed self-checking bench for proc_seq
// Inputs change and outputs are sampled 1 time unit after each rising edge.
module tb_proc_seq;
  import proc_pkg::*;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid, in_ready, flush, clr_err, w, Done, busy, err;
  logic [5:0] in_instr;
  logic [1:0] F, Rx, Ry;
  logic [7:0] done_cnt;
  logic [2:0] level;
  logic [5:0] instr_o;

  int tests = 0;
  int fails = 0;

  assign instr_o = {F, Rx, Ry};

  proc_seq #(.DEPTH(4), .TIMEOUT(8)) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_instr (in_instr),
    .flush    (flush),
    .clr_err  (clr_err),
    .w        (w),
    .F        (F),
    .Rx       (Rx),
    .Ry       (Ry),
    .Done     (Done),
    .busy     (busy),
    .err      (err),
    .done_cnt (done_cnt),
    .level    (level)
  );

  always #5 clk = ~clk;

  initial begin
    #50000;
    $display("FAIL watchdog: simulation did not finish, tests=%0d", tests);
    $fatal(1, "watchdog");
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  logic [5:0] q3 [5];

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_instr = '0; flush = 1'b0; clr_err = 1'b0; Done = 1'b0;
    q3[0] = 6'b00_11_10; q3[1] = 6'b01_10_11; q3[2] = 6'b10_01_00;
    q3[3] = 6'b11_00_01; q3[4] = 6'b01_11_11;
    tick; tick;
    check("rst_w", w, 0);
    check("rst_instr", instr_o, 0);
    check("rst_busy", busy, 0);
    check("rst_err", err, 0);
    check("rst_cnt", done_cnt, 0);
    check("rst_level", level, 0);
    check("rst_ready", in_ready, 1);
    rst = 1'b0;

    // Single LOAD
    in_valid = 1'b1; in_instr = make_instr(F_LOAD, 2'b01, 2'b00); tick;
    in_valid = 1'b0; check("t1_c1_w", w, 0); tick;
    check("t1_w", w, 1); check("t1_F", F, F_LOAD); check("t1_Rx", Rx, 1); tick;
    Done = 1'b1; check("t1_c3_w", w, 0); check("t1_c3_busy", busy, 1); tick;
    Done = 1'b0; check("t1_cnt", done_cnt, 1); check("t1_busy", busy, 0);

    // Back-to-back ADD then SUB
    in_valid = 1'b1; in_instr = 6'b11_10_01; tick;
    in_instr = 6'b10_00_11; tick;
    in_valid = 1'b0;
    check("t2_w1", w, 1); check("t2_i1", instr_o, 6'b11_10_01); check("t2_lvl", level, 1); tick;
    check("t2_w1_width", w, 0); tick; tick;
    Done = 1'b1; tick;
    Done = 1'b0;
    check("t2_w2", w, 1); check("t2_i2", instr_o, 6'b10_00_11); check("t2_cnt1", done_cnt, 2);
    tick; tick;
    Done = 1'b1; tick;
    Done = 1'b0; check("t2_cnt2", done_cnt, 3); check("t2_busy", busy, 0);

    // Full FIFO while held in S_WAIT
    in_valid = 1'b1; in_instr = 6'b01_00_01; tick;
    in_valid = 1'b0; tick;
    check("t3_w0", w, 1);
    in_valid = 1'b1; in_instr = q3[0]; tick;
    in_instr = q3[1]; tick;
    in_instr = q3[2]; tick;
    in_instr = q3[3]; tick;
    in_instr = q3[4];
    check("t3_full_lvl", level, 4); check("t3_full_rdy", in_ready, 0); tick;
    check("t3_full_rdy2", in_ready, 0);
    Done = 1'b1; tick;
    Done = 1'b0;
    check("t3_w1", w, 1); check("t3_i1", instr_o, q3[0]);
    check("t3_lvl3", level, 3); check("t3_rdy", in_ready, 1); tick;
    in_valid = 1'b0; check("t3_lvl4", level, 4);
    Done = 1'b1; tick;
    Done = 1'b0;
    for (int k = 1; k < 5; k++) begin
      check($sformatf("t3_w_%0d", k), w, 1);
      check($sformatf("t3_order_%0d", k), instr_o, q3[k]);
      tick;
      Done = 1'b1; tick;
      Done = 1'b0;
    end
    check("t3_cnt", done_cnt, 9); check("t3_lvl0", level, 0); check("t3_busy", busy, 0);

    // Timeout with one instruction queued behind
    in_valid = 1'b1; in_instr = 6'b01_10_00; tick;
    in_instr = 6'b00_01_01; tick;
    in_valid = 1'b0;
    check("t4_w", w, 1); check("t4_i", instr_o, 6'b01_10_00); check("t4_lvl", level, 1);
    repeat (8) tick;
    check("t4_pre_err", err, 0); check("t4_pre_busy", busy, 1); tick;
    check("t4_err", err, 1); check("t4_busy", busy, 0); check("t4_w_err", w, 0);
    check("t4_lvl_kept", level, 1);
    Done = 1'b1; tick;
    Done = 1'b0; check("t4_done_ign", done_cnt, 9); check("t4_err_sticky", err, 1);
    clr_err = 1'b1; tick;
    clr_err = 1'b0; check("t4_clr", err, 0); check("t4_clr_w", w, 0); tick;
    check("t4_w_next", w, 1); check("t4_i_next", instr_o, 6'b00_01_01); tick;
    Done = 1'b1; tick;
    Done = 1'b0; check("t4_cnt", done_cnt, 10);

    // Flush while in flight, then a spurious Done in S_IDLE
    in_valid = 1'b1; in_instr = 6'b11_01_10; tick;
    in_valid = 1'b0; tick;
    in_valid = 1'b1; in_instr = 6'b00_00_01; tick;
    in_instr = 6'b00_00_10; tick;
    in_instr = 6'b00_00_11; tick;
    check("t5_lvl3", level, 3);
    in_instr = 6'b01_01_01; flush = 1'b1; tick;
    flush = 1'b0; in_valid = 1'b0;
    check("t5_flush_lvl", level, 0); check("t5_busy", busy, 1); check("t5_rdy", in_ready, 1);
    Done = 1'b1; tick;
    Done = 1'b0;
    check("t5_cnt", done_cnt, 11); check("t5_idle", busy, 0); check("t5_lvl_after", level, 0);
    tick;
    Done = 1'b1; tick;
    Done = 1'b0; check("t5_spurious", done_cnt, 11); check("t5_w", w, 0);

    // Asynchronous reset one cycle after w
    in_valid = 1'b1; in_instr = 6'b11_11_11; tick;
    in_instr = 6'b10_01_10; tick;
    in_valid = 1'b0; check("t6_w", w, 1); tick;
    rst = 1'b1; #1;
    check("t6_rst_busy", busy, 0); check("t6_rst_instr", instr_o, 0);
    check("t6_rst_lvl", level, 0); check("t6_rst_cnt", done_cnt, 0);
    check("t6_rst_w", w, 0); check("t6_rst_rdy", in_ready, 1);
    #1; rst = 1'b0;
    tick;

    // Retire 256 instructions: issue every 2 cycles with Done held high
    in_valid = 1'b1; in_instr = make_instr(F_LOAD, 2'b00, 2'b01); Done = 1'b1;
    repeat (512) tick;
    check("t6_cnt255", done_cnt, 255);
    tick; tick;
    check("t6_wrap", done_cnt, 0); check("t6_wrap_w", w, 1); check("t6_wrap_err", err, 0);
    in_valid = 1'b0; Done = 1'b0;
    tick;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/proc_seq.md
Name: proc_seq

Overview:
Instruction sequencer placed in front of the proc_fsm control unit. It buffers {F,Rx,Ry} instructions from a host in a small FIFO and issues them one at a time as a single-cycle w pulse. For each instruction it waits for Done before issuing the next one. A watchdog flags a controller that never completes, and a wrapping counter tracks retired instructions.

Parameters:
DEPTH, 4, FIFO entries; power of 2, at least 2.
TIMEOUT, 8, consecutive S_WAIT cycles without Done before the error trips; at least 4.

Ports:
clk  in  1  system clock, rising edge.
rst  in  1  asynchronous, active-high reset.
in_valid  in  1  host offers instruction.
in_ready  out  1  FIFO can accept; equals !full.
in_instr  in  6  {F[5:4], Rx[3:2], Ry[1:0]}.
flush  in  1  synchronous; discards all FIFO contents.
clr_err  in  1  synchronous; leaves S_ERR.
w  out  1  issue strobe to proc_fsm.
F  out  2  opcode to proc_fsm.
Rx  out  2  destination/first operand to proc_fsm.
Ry  out  2  source/second operand to proc_fsm.
Done  in  1  completion from proc_fsm.
busy  out  1  high in S_ISSUE or S_WAIT.
err  out  1  sticky timeout flag.
done_cnt  out  8  retired-instruction count.
level  out  $clog2(DEPTH)+1  FIFO occupancy.

Behaviour:
- Reset values: w=0, F/Rx/Ry=0, busy=0, err=0, done_cnt=0, level=0, in_ready=1, state=S_IDLE, FIFO empty, timer=0.
- Push: occurs when in_valid && in_ready. in_ready is low whenever the FIFO is full, even if a pop happens in the same cycle.
- Simultaneous push and pop: both take effect and level is unchanged.
- Pop: never occurs when the FIFO is empty.
- Pointers: wrap modulo DEPTH. level ranges 0..DEPTH.
- cur_instr register: loaded from the FIFO head on every pop. F/Rx/Ry are driven from cur_instr and stay stable from S_ISSUE through S_WAIT.
- w: equals (state==S_ISSUE). It is exactly one cycle wide per instruction.
- S_IDLE: if the FIFO is non-empty, pop into cur_instr and go to S_ISSUE. Otherwise stay.
- S_ISSUE: assert w, clear the timer, go to S_WAIT.
- S_WAIT, Done=1: increment done_cnt (wraps 255 to 0).
  - If the FIFO is non-empty and flush=0, pop and go directly to S_ISSUE.
  - Otherwise go to S_IDLE.
- S_WAIT, Done=0: increment the timer. When the timer reaches TIMEOUT-1 without Done, go to S_ERR and set err.
- S_ERR:
  - w=0, busy=0; the FIFO is retained.
  - On clr_err, clear err and go to S_IDLE.
  - Done is ignored.
- Done outside S_WAIT: ignored; no count change.
- flush:
  - Empties the FIFO the same cycle; any simultaneous push is dropped.
  - Does not abort an in-flight instruction: S_WAIT still waits for Done, then goes to S_IDLE.
- Latency:
  - A push in cycle N into an empty FIFO while in S_IDLE gives w=1 in cycle N+2.
  - proc_fsm Done arrives at w+1 for LOAD/MOVE and at w+3 for F=10/11.
  - Back-to-back issue: the next w comes 1 cycle after the Done cycle.
- Reset mid-operation: the asynchronous clear returns everything to reset values. proc_fsm shares rst, so both blocks return to idle together; in-flight and queued instructions are lost.

Decomposition:
- Package proc_pkg:
  - Opcode constants: F_LOAD=2'b00, F_MOVE=2'b01, F_SUB=2'b10, F_ADD=2'b11.
  - Instruction field positions/widths.
  - Sequencer state encoding: S_IDLE, S_ISSUE, S_WAIT, S_ERR.
- Sub-module seq_fifo(DEPTH, WIDTH=6): synchronous FIFO with push, pop, flush, full, empty and level.
- proc_seq contains the FSM, timer, counter and cur_instr register.

Test Plan:
1. Single LOAD: after reset, push 6'b00_01_00 at cycle 0 -> w=1 at cycle 2 with F=00, Rx=01; model Done at cycle 3 -> done_cnt=1, busy=0 at cycle 4.
2. Back-to-back ALU: push ADD 6'b11_10_01 then SUB 6'b10_00_11 -> first w at cycle 2, Done at 5, second w at 6 with F=10, Rx=00, Ry=11, Done at 9 -> done_cnt=2.
3. Full FIFO: hold the model in S_WAIT and push 5 instructions -> in_ready=0 after 4 are accepted (level=4); 5th accepted only after a pop; issue order matches push order.
4. Timeout: issue MOVE with Done never asserted -> err=1 and state S_ERR after 8 S_WAIT cycles; queued instructions remain (level unchanged); clr_err -> next w two cycles later.
5. Flush plus spurious Done: 3 queued while in S_WAIT, assert flush -> level=0; Done completes the current instruction (done_cnt+1); a Done pulse in S_IDLE leaves done_cnt unchanged.
6. Reset mid-ALU and wrap: assert rst at w+1 -> all outputs return to reset values immediately. Separately, retire 256 instructions -> done_cnt=0.
